adder_ctrl: RTL and testbench
=============================

# adder_ctrl

Sequencing controller for the vector adder. It sits between the host CSR block and the TSIM memory port. On `launch` it walks the vector, computing c[i] = a[i] + b[i] for i = 0..length-1, with one read of a, one read of b and one write of c per element. When done it pulses `finish` and reports its cycle count on the event-counter port.

## Interface
Parameters:
- MEM_LEN_BITS, 8, width of mem_req_len
- MEM_ADDR_BITS, 64, memory byte-address width
- MEM_DATA_BITS, 64, memory data width; one element = one beat = MEM_DATA_BITS/8 bytes
- HOST_DATA_BITS, 32, width of CSR-sourced values

Ports:
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high
- launch  in  1  level; start request from CSR
- finish  out  1  one-cycle completion pulse
- event_counter_valid  out  1  one-cycle pulse, coincident with finish
- event_counter_value  out  HOST_DATA_BITS  cycle count of the run
- length  in  HOST_DATA_BITS  element count
- a_addr, b_addr, c_addr  in  HOST_DATA_BITS each  base byte addresses; zero-extended to MEM_ADDR_BITS
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted when valid & ready
- mem_req_opcode  out  1  1 = write, 0 = read
- mem_req_len  out  MEM_LEN_BITS  always 0 (one beat)
- mem_req_addr  out  MEM_ADDR_BITS  byte address
- mem_wr_valid  out  1  write data valid
- mem_wr_ready  in  1  write beat taken when valid & ready
- mem_wr_bits  out  MEM_DATA_BITS  write data
- mem_rd_valid  in  1  read data valid
- mem_rd_ready  out  1  read beat taken when valid & ready
- mem_rd_bits  in  MEM_DATA_BITS  read data

## Operation
- States: IDLE, REQ_A, DATA_A, REQ_B, DATA_B, REQ_C, DATA_C, DONE.
- IDLE:
  - launch=1 and length=0 -> DONE.
  - launch=1 and length≠0 -> REQ_A.
  - On leaving IDLE: index i ← 0, cycle counter ← 0, length and the three bases latched.
- REQ_A: mem_req_valid=1, opcode=0, addr = a_base + i·(MEM_DATA_BITS/8); on handshake -> DATA_A.
- DATA_A: mem_rd_ready=1; on handshake latch a_reg ← mem_rd_bits, -> REQ_B.
- REQ_B / DATA_B: same as the A states with b_base, latching b_reg.
- REQ_C: request with opcode=1 at c_base + i·(MEM_DATA_BITS/8); on handshake -> DATA_C.
- DATA_C: mem_wr_valid=1, mem_wr_bits = a_reg + b_reg. On handshake, i ← i+1, then:
  - i+1 == latched length -> DONE.
  - otherwise -> REQ_A.
- DONE: finish=1 and event_counter_valid=1 for exactly one cycle, then -> IDLE.
- Cycle counter increments every cycle the state is neither IDLE nor DONE. event_counter_value = counter value during DONE; it holds that value afterwards until the next launch clears it.
- Arithmetic:
  - Sum is modulo 2^MEM_DATA_BITS; carry-out discarded.
  - Address arithmetic is modulo 2^MEM_ADDR_BITS.
  - i and the counter are HOST_DATA_BITS wide.
- launch is ignored outside IDLE. CSR register 0 is written to 2 on finish, so launch is low by the time the block returns to IDLE.
- Changes to length or addresses mid-run have no effect (latched values are used).
- Only one memory transaction is outstanding at a time. No request is issued before the previous data beat completes.

## Timing
- Reset values:
  - finish, event_counter_valid, mem_req_valid, mem_wr_valid, mem_rd_ready = 0
  - event_counter_value, mem_req_addr, mem_wr_bits = 0
  - mem_req_opcode = 0, mem_req_len = 0
  - state = IDLE
- Reset mid-run: the block returns to IDLE the next cycle with all valids low and no finish pulse. The in-flight transaction is abandoned.
- All outputs are registered or decoded from state only; there is no combinational path from any ready input to any valid output.
- Handshake rule: once asserted, a valid and its addr/opcode/bits stay stable until accepted.
- Minimum per-element cost is 6 cycles: one cycle per state, with ready/valid high on the first cycle of each state.
- finish appears 1 cycle after the final DATA_C handshake. For length=0 it appears 1 cycle after launch is sampled.

## Test plan
- Reset, then launch with length=0 -> finish pulses exactly once 1 cycle later; event_counter_value=0; no mem_req_valid ever asserted.
- length=1, a_addr=0x100, b_addr=0x200, c_addr=0x300, memory always ready, read data valid in the first DATA cycle, a=5, b=7 -> reads issued at 0x100 then 0x200, write of 12 at 0x300, finish pulses, event_counter_value=6.
- length=4, a[i]=i, b[i]=10·i, contiguous buffers -> writes 0, 11, 22, 33 at c_addr+0, +8, +16, +24 in order; event_counter_value=24.
- length=1, a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> write data 1 (wrap). Randomized backpressure on mem_req_ready, mem_wr_ready and mem_rd_valid -> same data; counter = 6 + total stall cycles; valids and payloads stable while stalled.
- Assert reset during DATA_B of element 2 with length=5 -> no further memory activity and no finish. A relaunch with length=2 completes normally with correct data.
- Pulse launch again mid-run and change length/c_addr mid-run -> ignored; the original run completes with its latched parameters and only one finish pulse.

Source files
------------

// File: rtl/adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// adder_ctrl_if
// Memory-port bundle between the vector-adder sequencer and the TSIM memory.
//   request channel : mem_req_valid/ready, mem_req_opcode (1=write),
//                     mem_req_len (beats-1), mem_req_addr (byte address)
//   write channel   : mem_wr_valid/ready, mem_wr_bits
//   read channel    : mem_rd_valid/ready, mem_rd_bits
// master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface adder_ctrl_if #(
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 64,
   parameter int MEM_DATA_BITS = 64
);
   logic                     mem_req_valid;
   logic                     mem_req_ready;
   logic                     mem_req_opcode;
   logic [MEM_LEN_BITS-1:0]  mem_req_len;
   logic [MEM_ADDR_BITS-1:0] mem_req_addr;
   logic                     mem_wr_valid;
   logic                     mem_wr_ready;
   logic [MEM_DATA_BITS-1:0] mem_wr_bits;
   logic                     mem_rd_valid;
   logic                     mem_rd_ready;
   logic [MEM_DATA_BITS-1:0] mem_rd_bits;

   modport master (
      output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
      output mem_wr_valid, mem_wr_bits, mem_rd_ready,
      input  mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
   );

   modport slave (
      input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
      input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
      output mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
   );
endinterface

// File: rtl/adder_ctrl.sv
// -----------------------------------------------------------------------------
// adder_ctrl
// Sequencer for the vector adder: on launch it computes c[i] = a[i] + b[i]
// for i = 0..length-1, one read of a, one read of b and one write of c per
// element, strictly one memory transaction at a time. At the end it pulses
// finish together with event_counter_valid and reports the number of active
// cycles on event_counter_value.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   launch                : level start request (only looked at when idle)
//   finish                : one-cycle completion pulse
//   event_counter_valid   : one-cycle pulse, coincident with finish
//   event_counter_value   : active-cycle count of the last run
//   length, a/b/c_addr    : run parameters, latched at launch
//   mem                   : memory port bundle (master side)
// -----------------------------------------------------------------------------
module adder_ctrl #(
   parameter int MEM_LEN_BITS   = 8,
   parameter int MEM_ADDR_BITS  = 64,
   parameter int MEM_DATA_BITS  = 64,
   parameter int HOST_DATA_BITS = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      launch,
   output logic                      finish,
   output logic                      event_counter_valid,
   output logic [HOST_DATA_BITS-1:0] event_counter_value,
   input  logic [HOST_DATA_BITS-1:0] length,
   input  logic [HOST_DATA_BITS-1:0] a_addr,
   input  logic [HOST_DATA_BITS-1:0] b_addr,
   input  logic [HOST_DATA_BITS-1:0] c_addr,
   adder_ctrl_if.master              mem
);

   localparam logic [MEM_ADDR_BITS-1:0]  BEAT_BYTES = MEM_ADDR_BITS'(MEM_DATA_BITS / 8);
   localparam logic [HOST_DATA_BITS-1:0] HOST_ONE   = HOST_DATA_BITS'(1'b1);
   localparam logic [HOST_DATA_BITS-1:0] HOST_ZERO  = {HOST_DATA_BITS{1'b0}};
   localparam logic [MEM_ADDR_BITS-1:0]  ADDR_ZERO  = {MEM_ADDR_BITS{1'b0}};
   localparam logic [MEM_DATA_BITS-1:0]  DATA_ZERO  = {MEM_DATA_BITS{1'b0}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_A  = 3'd1,
      DATA_A = 3'd2,
      REQ_B  = 3'd3,
      DATA_B = 3'd4,
      REQ_C  = 3'd5,
      DATA_C = 3'd6,
      DONE   = 3'd7
   } state_t;

   state_t                    state_q;
   logic [HOST_DATA_BITS-1:0] len_q;
   logic [HOST_DATA_BITS-1:0] a_base_q;
   logic [HOST_DATA_BITS-1:0] b_base_q;
   logic [HOST_DATA_BITS-1:0] c_base_q;
   logic [HOST_DATA_BITS-1:0] idx_q;
   logic [HOST_DATA_BITS-1:0] cnt_q;
   logic [MEM_DATA_BITS-1:0]  a_q;
   logic [MEM_DATA_BITS-1:0]  b_q;
   logic                      finish_q;
   logic                      req_valid_q;
   logic                      req_opcode_q;
   logic [MEM_ADDR_BITS-1:0]  req_addr_q;
   logic                      wr_valid_q;
   logic [MEM_DATA_BITS-1:0]  wr_bits_q;
   logic                      rd_ready_q;

   logic                      req_fire_s;
   logic                      rd_fire_s;
   logic                      wr_fire_s;
   logic [HOST_DATA_BITS-1:0] idx_next_s;
   logic [HOST_DATA_BITS-1:0] cnt_inc_s;
   logic [MEM_DATA_BITS-1:0]  sum_s;

   // Byte address of element idx in the buffer starting at base (wraps modulo 2^MEM_ADDR_BITS).
   function automatic logic [MEM_ADDR_BITS-1:0] elem_addr(
      input logic [HOST_DATA_BITS-1:0] base,
      input logic [HOST_DATA_BITS-1:0] idx
   );
      logic [MEM_ADDR_BITS-1:0] base_ext;
      logic [MEM_ADDR_BITS-1:0] idx_ext;
      base_ext = MEM_ADDR_BITS'(base);
      idx_ext  = MEM_ADDR_BITS'(idx);
      return base_ext + idx_ext * BEAT_BYTES;
   endfunction

   // Handshake qualifiers, next index, next cycle count and element sum (carry discarded).
   always_comb begin
      req_fire_s = req_valid_q & mem.mem_req_ready;
      rd_fire_s  = rd_ready_q & mem.mem_rd_valid;
      wr_fire_s  = wr_valid_q & mem.mem_wr_ready;
      idx_next_s = idx_q + HOST_ONE;
      cnt_inc_s  = cnt_q + HOST_ONE;
      sum_s      = a_q + b_q;
   end

   // Sequencer FSM; every output is a register loaded on the transition into its state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= HOST_ZERO;
         a_base_q     <= HOST_ZERO;
         b_base_q     <= HOST_ZERO;
         c_base_q     <= HOST_ZERO;
         idx_q        <= HOST_ZERO;
         cnt_q        <= HOST_ZERO;
         a_q          <= DATA_ZERO;
         b_q          <= DATA_ZERO;
         finish_q     <= 1'b0;
         req_valid_q  <= 1'b0;
         req_opcode_q <= 1'b0;
         req_addr_q   <= ADDR_ZERO;
         wr_valid_q   <= 1'b0;
         wr_bits_q    <= DATA_ZERO;
         rd_ready_q   <= 1'b0;
      end else begin
         finish_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  len_q    <= length;
                  a_base_q <= a_addr;
                  b_base_q <= b_addr;
                  c_base_q <= c_addr;
                  idx_q    <= HOST_ZERO;
                  cnt_q    <= HOST_ZERO;
                  if (length == HOST_ZERO) begin
                     state_q  <= DONE;
                     finish_q <= 1'b1;
                  end else begin
                     state_q      <= REQ_A;
                     req_valid_q  <= 1'b1;
                     req_opcode_q <= 1'b0;
                     req_addr_q   <= elem_addr(a_addr, HOST_ZERO);
                  end
               end
            end
            REQ_A, REQ_B: begin
               cnt_q <= cnt_inc_s;
               if (req_fire_s) begin
                  req_valid_q <= 1'b0;
                  rd_ready_q  <= 1'b1;
                  state_q     <= (state_q == REQ_A) ? DATA_A : DATA_B;
               end
            end
            DATA_A: begin
               cnt_q <= cnt_inc_s;
               if (rd_fire_s) begin
                  a_q          <= mem.mem_rd_bits;
                  rd_ready_q   <= 1'b0;
                  req_valid_q  <= 1'b1;
                  req_opcode_q <= 1'b0;
                  req_addr_q   <= elem_addr(b_base_q, idx_q);
                  state_q      <= REQ_B;
               end
            end
            DATA_B: begin
               cnt_q <= cnt_inc_s;
               if (rd_fire_s) begin
                  b_q          <= mem.mem_rd_bits;
                  rd_ready_q   <= 1'b0;
                  req_valid_q  <= 1'b1;
                  req_opcode_q <= 1'b1;
                  req_addr_q   <= elem_addr(c_base_q, idx_q);
                  state_q      <= REQ_C;
               end
            end
            REQ_C: begin
               cnt_q <= cnt_inc_s;
               if (req_fire_s) begin
                  req_valid_q <= 1'b0;
                  wr_valid_q  <= 1'b1;
                  wr_bits_q   <= sum_s;
                  state_q     <= DATA_C;
               end
            end
            DATA_C: begin
               cnt_q <= cnt_inc_s;
               if (wr_fire_s) begin
                  wr_valid_q <= 1'b0;
                  idx_q      <= idx_next_s;
                  if (idx_next_s == len_q) begin
                     state_q  <= DONE;
                     finish_q <= 1'b1;
                  end else begin
                     state_q      <= REQ_A;
                     req_valid_q  <= 1'b1;
                     req_opcode_q <= 1'b0;
                     req_addr_q   <= elem_addr(a_base_q, idx_next_s);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               req_valid_q <= 1'b0;
               wr_valid_q  <= 1'b0;
               rd_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign finish              = finish_q;
   assign event_counter_valid = finish_q;
   // The counter is frozen outside the active states, so it holds the run's count until the next launch.
   assign event_counter_value = cnt_q;

   assign mem.mem_req_valid  = req_valid_q;
   assign mem.mem_req_opcode = req_opcode_q;
   assign mem.mem_req_len    = {MEM_LEN_BITS{1'b0}};
   assign mem.mem_req_addr   = req_addr_q;
   assign mem.mem_wr_valid   = wr_valid_q;
   assign mem.mem_wr_bits    = wr_bits_q;
   assign mem.mem_rd_ready   = rd_ready_q;

endmodule

// File: tb/tb_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_ctrl
// Self-checking bench: a memory responder with optional random backpressure,
// and a reference model that turns each accepted launch into the expected
// request sequence, write data and cycle count.
// -----------------------------------------------------------------------------
module tb_adder_ctrl;
   localparam int LB = 8;
   localparam int AB = 64;
   localparam int DB = 64;
   localparam int HB = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          launch;
   logic          finish;
   logic          ecv;
   logic [HB-1:0] ecval;
   logic [HB-1:0] length;
   logic [HB-1:0] a_addr;
   logic [HB-1:0] b_addr;
   logic [HB-1:0] c_addr;

   adder_ctrl_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) mif ();

   adder_ctrl #(
      .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .HOST_DATA_BITS(HB)
   ) dut (
      .clock(clock), .reset(reset), .launch(launch), .finish(finish),
      .event_counter_valid(ecv), .event_counter_value(ecval), .length(length),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .mem(mif)
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad = 0;
   bit          bp_en = 1'b0;
   logic [63:0] mem_m [bit [63:0]];
   logic [64:0] exp_req_q[$];
   logic [63:0] exp_dat_q[$];
   bit          busy = 1'b0, fin_due = 1'b0, rst_seen = 1'b0;
   bit          rd_pend = 1'b0, wr_pend = 1'b0, pv_req = 1'b0, pv_wr = 1'b0;
   logic [63:0] rd_addr, wr_addr, pv_addr, pv_bits;
   logic        pv_op;
   int          stall = 0, run_len = 0, fin_total = 0, req_total = 0, rd_req_cnt = 0;
   logic [31:0] last_cnt = 32'd0;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory responder plus reference model and per-cycle compare, all evaluated at negedge.
   initial begin : mem_proc
      logic [64:0] e;
      logic [63:0] d, aa, bb, cc;
      mif.mem_req_ready = 1'b0;
      mif.mem_wr_ready  = 1'b0;
      mif.mem_rd_valid  = 1'b0;
      mif.mem_rd_bits   = 64'd0;
      forever begin
         @(negedge clock);
         if (rst_seen) begin
            chk({finish, ecv, mif.mem_req_valid, mif.mem_wr_valid, mif.mem_rd_ready} === 5'b0,
                "rst_ctl", {59'd0, finish, ecv, mif.mem_req_valid, mif.mem_wr_valid, mif.mem_rd_ready}, 64'd0);
            chk(ecval === 32'd0 && mif.mem_req_opcode === 1'b0 && mif.mem_req_len === 8'd0,
                "rst_cnt", {32'd0, ecval}, 64'd0);
            chk(mif.mem_req_addr === 64'd0, "rst_addr", mif.mem_req_addr, 64'd0);
            chk(mif.mem_wr_bits === 64'd0, "rst_wbits", mif.mem_wr_bits, 64'd0);
         end
         if (pv_req)
            chk(mif.mem_req_valid === 1'b1 && mif.mem_req_addr === pv_addr && mif.mem_req_opcode === pv_op,
                "req_hold", mif.mem_req_addr, pv_addr);
         if (pv_wr)
            chk(mif.mem_wr_valid === 1'b1 && mif.mem_wr_bits === pv_bits, "wr_hold", mif.mem_wr_bits, pv_bits);
         chk(finish === fin_due, "finish", {63'd0, finish}, {63'd0, fin_due});
         chk(ecv === fin_due, "ev_valid", {63'd0, ecv}, {63'd0, fin_due});
         if (finish === 1'b1) begin
            last_cnt = ecval;
            fin_total++;
            if (fin_due)
               chk(ecval === 32'(6 * run_len + stall), "count", {32'd0, ecval}, 64'(6 * run_len + stall));
            busy = 1'b0;
         end
         fin_due = 1'b0;
         if (reset === 1'b1) begin
            exp_req_q.delete();
            exp_dat_q.delete();
            busy = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0; pv_req = 1'b0; pv_wr = 1'b0;
            rst_seen = 1'b1;
            mif.mem_req_ready = 1'b0;
            mif.mem_wr_ready  = 1'b0;
            mif.mem_rd_valid  = 1'b0;
            continue;
         end
         rst_seen = 1'b0;
         // one transaction at a time
         if (mif.mem_req_valid === 1'b1)
            chk(!rd_pend && !wr_pend, "overlap", {62'd0, rd_pend, wr_pend}, 64'd0);
         if (mif.mem_rd_ready === 1'b1)
            chk(rd_pend, "rd_ready_spur", 64'd1, {63'd0, rd_pend});
         if (mif.mem_wr_valid === 1'b1)
            chk(wr_pend, "wr_valid_spur", 64'd1, {63'd0, wr_pend});
         // drive the memory side for the coming edge
         mif.mem_req_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         mif.mem_wr_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rd_pend) begin
            if (mif.mem_rd_valid !== 1'b1)
               mif.mem_rd_valid = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            mif.mem_rd_bits = mem_m[rd_addr];
         end else begin
            mif.mem_rd_valid = 1'b0;
            mif.mem_rd_bits  = {$urandom, $urandom};
         end
         if ((mif.mem_req_valid === 1'b1 && !mif.mem_req_ready) ||
             (mif.mem_wr_valid === 1'b1 && !mif.mem_wr_ready) ||
             (mif.mem_rd_ready === 1'b1 && !mif.mem_rd_valid))
            stall++;
         // handshakes that complete at the coming edge
         if (mif.mem_rd_ready === 1'b1 && mif.mem_rd_valid)
            rd_pend = 1'b0;
         if (mif.mem_req_valid === 1'b1 && mif.mem_req_ready) begin
            req_total++;
            chk(mif.mem_req_len === 8'd0, "req_len", {56'd0, mif.mem_req_len}, 64'd0);
            if (exp_req_q.size() == 0) begin
               chk(1'b0, "unexp_req", mif.mem_req_addr, 64'd0);
            end else begin
               e = exp_req_q.pop_front();
               chk(mif.mem_req_addr === e[63:0] && mif.mem_req_opcode === e[64], "req",
                   mif.mem_req_addr, e[63:0]);
            end
            if (mif.mem_req_opcode === 1'b0) begin
               rd_pend = 1'b1; rd_addr = mif.mem_req_addr; rd_req_cnt++;
            end else begin
               wr_pend = 1'b1; wr_addr = mif.mem_req_addr;
            end
         end
         if (mif.mem_wr_valid === 1'b1 && mif.mem_wr_ready) begin
            if (exp_dat_q.size() == 0) begin
               chk(1'b0, "unexp_wr", mif.mem_wr_bits, 64'd0);
            end else begin
               d = exp_dat_q.pop_front();
               chk(mif.mem_wr_bits === d, "wdata", mif.mem_wr_bits, d);
            end
            mem_m[wr_addr] = mif.mem_wr_bits;
            wr_pend = 1'b0;
            if (busy && exp_dat_q.size() == 0 && exp_req_q.size() == 0)
               fin_due = 1'b1;
         end
         pv_req = (mif.mem_req_valid === 1'b1) && !mif.mem_req_ready;
         pv_addr = mif.mem_req_addr;
         pv_op = mif.mem_req_opcode;
         pv_wr = (mif.mem_wr_valid === 1'b1) && !mif.mem_wr_ready;
         pv_bits = mif.mem_wr_bits;
         // a launch seen while idle is sampled at the coming edge
         if (!busy && launch === 1'b1) begin
            busy = 1'b1;
            stall = 0;
            run_len = int'(length);
            for (int i = 0; i < run_len; i++) begin
               aa = 64'(a_addr) + 64'(i) * 64'd8;
               bb = 64'(b_addr) + 64'(i) * 64'd8;
               cc = 64'(c_addr) + 64'(i) * 64'd8;
               exp_req_q.push_back({1'b0, aa});
               exp_req_q.push_back({1'b0, bb});
               exp_req_q.push_back({1'b1, cc});
               exp_dat_q.push_back(mem_m[aa] + mem_m[bb]);
            end
            if (run_len == 0) fin_due = 1'b1;
         end
      end
   end

   task automatic do_launch(input int len, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      @(posedge clock); #2;
      length = 32'(len); a_addr = a; b_addr = b; c_addr = c; launch = 1'b1;
      @(posedge clock); #2;
      launch = 1'b0;
   endtask

   task automatic wait_fin(input int f0);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clock);
         if (fin_total > f0) begin got = 1'b1; break; end
      end
      if (!got) chk(1'b0, "timeout", 64'(fin_total), 64'(f0 + 1));
      repeat (4) @(posedge clock);
      chk(fin_total == f0 + 1, "one_finish", 64'(fin_total), 64'(f0 + 1));
   endtask

   task automatic fill(input int len, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      for (int i = 0; i < len; i++) begin
         mem_m[64'(a) + 64'(i) * 64'd8] = {$urandom, $urandom};
         mem_m[64'(b) + 64'(i) * 64'd8] = {$urandom, $urandom};
         mem_m[64'(c) + 64'(i) * 64'd8] = 64'hDEAD_BEEF_0000_0000;
      end
   endtask

   // Directed scenarios followed by randomized runs.
   initial begin : main
      int f0, r0, base, len;
      logic [31:0] ra, rb, rc;
      reset = 1'b1; launch = 1'b0; length = 32'd0;
      a_addr = 32'd0; b_addr = 32'd0; c_addr = 32'd0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);

      // zero length: finish one cycle later, count 0, no memory traffic
      f0 = fin_total; r0 = req_total;
      do_launch(0, 32'h100, 32'h200, 32'h300);
      wait_fin(f0);
      chk(last_cnt == 32'd0, "len0_cnt", {32'd0, last_cnt}, 64'd0);
      chk(req_total == r0, "len0_noreq", 64'(req_total), 64'(r0));

      // single element 5 + 7
      mem_m[64'h100] = 64'd5; mem_m[64'h200] = 64'd7; mem_m[64'h300] = 64'd0;
      f0 = fin_total;
      do_launch(1, 32'h100, 32'h200, 32'h300);
      wait_fin(f0);
      chk(mem_m[64'h300] == 64'd12, "l1_sum", mem_m[64'h300], 64'd12);
      chk(last_cnt == 32'd6, "l1_cnt", {32'd0, last_cnt}, 64'd6);
      #1 chk(ecval === 32'd6, "l1_hold", {32'd0, ecval}, 64'd6);

      // four elements a[i]=i, b[i]=10i, contiguous buffers
      for (int i = 0; i < 4; i++) begin
         mem_m[64'h400 + 64'(i) * 64'd8] = 64'(i);
         mem_m[64'h420 + 64'(i) * 64'd8] = 64'(10 * i);
         mem_m[64'h440 + 64'(i) * 64'd8] = 64'hFFFF;
      end
      f0 = fin_total;
      do_launch(4, 32'h400, 32'h420, 32'h440);
      wait_fin(f0);
      for (int i = 0; i < 4; i++)
         chk(mem_m[64'h440 + 64'(i) * 64'd8] == 64'(11 * i), "l4_sum",
             mem_m[64'h440 + 64'(i) * 64'd8], 64'(11 * i));
      chk(last_cnt == 32'd24, "l4_cnt", {32'd0, last_cnt}, 64'd24);

      // wrap-around sum under backpressure
      bp_en = 1'b1;
      mem_m[64'h500] = 64'hFFFF_FFFF_FFFF_FFFF; mem_m[64'h508] = 64'd2; mem_m[64'h510] = 64'd0;
      f0 = fin_total;
      do_launch(1, 32'h500, 32'h508, 32'h510);
      wait_fin(f0);
      chk(mem_m[64'h510] == 64'd1, "wrap_sum", mem_m[64'h510], 64'd1);

      // reset during DATA_B of element 2, then relaunch
      bp_en = 1'b0;
      fill(5, 32'h1000, 32'h2000, 32'h3000);
      base = rd_req_cnt; f0 = fin_total;
      do_launch(5, 32'h1000, 32'h2000, 32'h3000);
      for (int n = 0; n < 500; n++) begin
         if (rd_req_cnt >= base + 6) break;
         @(posedge clock);
      end
      chk(rd_req_cnt == base + 6, "rst_reach", 64'(rd_req_cnt), 64'(base + 6));
      @(posedge clock); #2 reset = 1'b1;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      r0 = req_total;
      repeat (20) @(posedge clock);
      chk(fin_total == f0, "rst_nofin", 64'(fin_total), 64'(f0));
      chk(req_total == r0, "rst_noreq", 64'(req_total), 64'(r0));
      chk(mem_m[64'h3010] == 64'hDEAD_BEEF_0000_0000, "rst_nowrite", mem_m[64'h3010], 64'hDEAD_BEEF_0000_0000);
      bp_en = 1'b1;
      fill(2, 32'h1100, 32'h2100, 32'h3100);
      f0 = fin_total;
      do_launch(2, 32'h1100, 32'h2100, 32'h3100);
      wait_fin(f0);

      // mid-run launch pulse and parameter change are ignored
      fill(3, 32'h4000, 32'h5000, 32'h6000);
      mem_m[64'h7000] = 64'h5A5A;
      f0 = fin_total;
      do_launch(3, 32'h4000, 32'h5000, 32'h6000);
      repeat (6) @(posedge clock);
      #2 launch = 1'b1; length = 32'd7; c_addr = 32'h7000;
      @(posedge clock); #2 launch = 1'b0;
      wait_fin(f0);
      chk(mem_m[64'h7000] == 64'h5A5A, "mid_c_ignored", mem_m[64'h7000], 64'h5A5A);

      // randomized runs
      for (int r = 0; r < 8; r++) begin
         bp_en = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 6);
         ra = 32'h1000_0000 + (32'($urandom_range(0, 1023)) << 3);
         rb = 32'h2000_0000 + (32'($urandom_range(0, 1023)) << 3);
         rc = 32'h3000_0000 + (32'($urandom_range(0, 1023)) << 3);
         fill(len, ra, rb, rc);
         f0 = fin_total;
         do_launch(len, ra, rb, rc);
         wait_fin(f0);
      end

      repeat (5) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
